dcache_controller: RTL and testbench

Direct-mapped, write-back data cache controller sitting between the 8-bit CPU's load/store path and the 32-bit-word data memory. It resolves CPU byte accesses as hits in a local 8-block × 4-byte array. On a miss it stalls the CPU through BUSYWAIT, writes back a dirty victim if needed, and fetches the missing block from memory.

---
 rtl/dcache_pkg.sv | 26 ++
 rtl/dcache_if.sv | 27 ++
 rtl/dcache_array.sv | 61 ++++++
 rtl/dcache_controller.sv | 125 ++++++++++++
 tb/tb_dcache_controller.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// Shared geometry, state encoding and helpers for the direct-mapped write-back data cache.
package dcache_pkg;

    localparam int TAG_W    = 3;
    localparam int INDEX_W  = 3;
    localparam int OFFSET_W = 2;
    localparam int BLOCKS   = 8;
    localparam int BLOCK_W  = 32;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WRITEBACK = 2'd1;
    localparam logic [1:0] FETCH     = 2'd2;
    localparam logic [1:0] UPDATE    = 2'd3;

    typedef logic [TAG_W-1:0]           tag_t;
    typedef logic [INDEX_W-1:0]         index_t;
    typedef logic [OFFSET_W-1:0]        offset_t;
    typedef logic [BLOCK_W-1:0]         block_t;
    typedef logic [TAG_W+INDEX_W-1:0]   maddr_t;

    // Byte 0 of a block lives in bits [7:0].
    function automatic logic [7:0] block_byte(input block_t blk, input offset_t off);
        return blk[{off, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU load/store and block-memory bus seen by the data cache controller.
interface dcache_if;

    logic                   READ;
    logic                   WRITE;
    logic [7:0]             ADDRESS;
    logic [7:0]             WRITEDATA;
    logic [7:0]             READDATA;
    logic                   BUSYWAIT;
    logic                   MEM_READ;
    logic                   MEM_WRITE;
    dcache_pkg::maddr_t     MEM_ADDRESS;
    dcache_pkg::block_t     MEM_WRITEDATA;
    dcache_pkg::block_t     MEM_READDATA;
    logic                   MEM_BUSYWAIT;

    modport slave (
        input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
        output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );

    modport master (
        output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
        input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );

endinterface

// File: rtl/dcache_array.sv
// Cache storage: per-block valid/dirty/tag/data with async clear, byte-write and block-fill ports.
module dcache_array
    import dcache_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  index_t      index_i,
    input  logic        byte_we_i,
    input  offset_t     offset_i,
    input  logic [7:0]  byte_i,
    input  logic        fill_i,
    input  tag_t        fill_tag_i,
    input  block_t      fill_data_i,
    output logic        valid_o,
    output logic        dirty_o,
    output tag_t        tag_o,
    output block_t      data_o
);

    logic   [BLOCKS-1:0] valid_q, valid_d;
    logic   [BLOCKS-1:0] dirty_q, dirty_d;
    tag_t   [BLOCKS-1:0] tag_q,   tag_d;
    block_t [BLOCKS-1:0] data_q,  data_d;

    // A fill always wins; the controller never asserts both in one cycle.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_i) begin
            valid_d[index_i] = 1'b1;
            dirty_d[index_i] = 1'b0;
            tag_d[index_i]   = fill_tag_i;
            data_d[index_i]  = fill_data_i;
        end else if (byte_we_i) begin
            data_d[index_i][{offset_i, 3'b000} +: 8] = byte_i;
            dirty_d[index_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            dirty_q <= '0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q[index_i];
    assign dirty_o = dirty_q[index_i];
    assign tag_o   = tag_q[index_i];
    assign data_o  = data_q[index_i];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache controller (FSM + hit logic).
// Optional DCACHE_STATS_EN adds saturating HIT_COUNT / MISS_COUNT outputs.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    dcache_if.slave     bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0] HIT_COUNT,
    output logic [15:0] MISS_COUNT
`endif
);

    logic [1:0] state_q, state_d;

    tag_t    addr_tag;
    index_t  addr_index;
    offset_t addr_offset;
    logic    req;
    logic    hit;
    logic    idle_hit;

    logic    blk_valid;
    logic    blk_dirty;
    tag_t    blk_tag;
    block_t  blk_data;

    assign addr_tag    = bus.ADDRESS[7:5];
    assign addr_index  = bus.ADDRESS[4:2];
    assign addr_offset = bus.ADDRESS[1:0];
    assign req         = bus.READ | bus.WRITE;
    assign hit         = blk_valid && (blk_tag == addr_tag);
    assign idle_hit    = (state_q == IDLE) && hit;

    dcache_array u_array (
        .clk_i       (CLK),
        .rst_ni      (RESET),
        .index_i     (addr_index),
        .byte_we_i   (idle_hit && bus.WRITE),
        .offset_i    (addr_offset),
        .byte_i      (bus.WRITEDATA),
        .fill_i      (state_q == UPDATE),
        .fill_tag_i  (addr_tag),
        .fill_data_i (bus.MEM_READDATA),
        .valid_o     (blk_valid),
        .dirty_o     (blk_dirty),
        .tag_o       (blk_tag),
        .data_o      (blk_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    state_d = (blk_valid && blk_dirty) ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: if (!bus.MEM_BUSYWAIT) state_d = FETCH;
            FETCH:     if (!bus.MEM_BUSYWAIT) state_d = UPDATE;
            UPDATE:    state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobes decode the registered state so reset drops them asynchronously.
    always_comb begin
        bus.MEM_READ      = 1'b0;
        bus.MEM_WRITE     = 1'b0;
        bus.MEM_ADDRESS   = '0;
        bus.MEM_WRITEDATA = '0;
        case (state_q)
            WRITEBACK: begin
                bus.MEM_WRITE     = 1'b1;
                bus.MEM_ADDRESS   = {blk_tag, addr_index};
                bus.MEM_WRITEDATA = blk_data;
            end
            FETCH: begin
                bus.MEM_READ    = 1'b1;
                bus.MEM_ADDRESS = {addr_tag, addr_index};
            end
            default: ;
        endcase
    end

    assign bus.BUSYWAIT = req && !idle_hit;
    assign bus.READDATA = (bus.READ && idle_hit) ? block_byte(blk_data, addr_offset) : 8'h00;

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;
    logic        from_update_q;

    // The hit that completes a refilled request is not a fresh hit.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
            from_update_q <= 1'b0;
        end else begin
            from_update_q <= (state_q == UPDATE);
            if (idle_hit && req && !from_update_q && (hit_cnt_q != '1)) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
            end
            if ((state_q == IDLE) && (state_d != IDLE) && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign HIT_COUNT  = hit_cnt_q;
    assign MISS_COUNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: directed scenarios, then random traffic vs a byte-level model.
module tb_dcache_controller;
    import dcache_pkg::*;

    localparam int LAT = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dcache_if bus();

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    dcache_controller dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
`ifdef DCACHE_STATS_EN
        ,
        .HIT_COUNT  (hit_cnt),
        .MISS_COUNT (miss_cnt)
`endif
    );

    // Block memory: busy for the first LAT-1 cycles of a strobe, done in cycle LAT.
    logic [31:0] mem [64];
    logic [31:0] mem_rdata_q;
    int          mem_cnt;
    logic        mem_busy;

    assign mem_busy         = (bus.MEM_READ || bus.MEM_WRITE) && (mem_cnt < LAT - 1);
    assign bus.MEM_BUSYWAIT = mem_busy;
    assign bus.MEM_READDATA = mem_rdata_q;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] <= $urandom;
        mem[9]      <= 32'hDDCCBBAA;
        mem_cnt     <= 0;
        mem_rdata_q <= '0;
    end

    always @(posedge clk) begin
        if ((bus.MEM_READ || bus.MEM_WRITE) && !mem_busy) begin
            mem_cnt <= 0;
            if (bus.MEM_WRITE) mem[bus.MEM_ADDRESS] <= bus.MEM_WRITEDATA;
            else               mem_rdata_q <= mem[bus.MEM_ADDRESS];
        end else if (bus.MEM_READ || bus.MEM_WRITE) begin
            mem_cnt <= mem_cnt + 1;
        end else begin
            mem_cnt <= 0;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Results of the last CPU request.
    logic [7:0]  r_data;
    int          r_stall;
    logic        r_wb, r_fe;
    logic [5:0]  r_wb_addr, r_fe_addr;
    logic [31:0] r_wb_data;

    // Called at a negedge; returns at a negedge with the request dropped.
    task automatic cpu_req(input logic rd, input logic wr, input logic [7:0] addr, input logic [7:0] wd);
        r_stall = 0; r_wb = 1'b0; r_fe = 1'b0;
        r_wb_addr = '0; r_fe_addr = '0; r_wb_data = '0;
        bus.READ = rd; bus.WRITE = wr; bus.ADDRESS = addr; bus.WRITEDATA = wd;
        #1;
        while (bus.BUSYWAIT && r_stall < 200) begin
            if (bus.MEM_WRITE && !r_wb) begin
                r_wb = 1'b1; r_wb_addr = bus.MEM_ADDRESS; r_wb_data = bus.MEM_WRITEDATA;
            end
            if (bus.MEM_READ && !r_fe) begin
                r_fe = 1'b1; r_fe_addr = bus.MEM_ADDRESS;
            end
            @(negedge clk); #1;
            r_stall++;
        end
        r_data = bus.READDATA;
        @(negedge clk);
        bus.READ = 1'b0; bus.WRITE = 1'b0;
    endtask

    // Reference model: bytes per block, word memory.
    logic       rv  [8];
    logic       rdy [8];
    logic [2:0] rt  [8];
    logic [7:0] rb  [8][4];
    logic [31:0] mem_ref [64];

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] m29;
        int          n, cyc, nh, nm, kind, exp_stall;
        logic [2:0]  tg, ix;
        logic [1:0]  of;
        logic [7:0]  a, wd;
        logic        hitm, wbm;
        logic [5:0]  vaddr;

        rst_n = 1'b0;
        bus.READ = 1'b0; bus.WRITE = 1'b0; bus.ADDRESS = '0; bus.WRITEDATA = '0;
        repeat (2) @(negedge clk);
        check("rst_busywait",  bus.BUSYWAIT, 0);
        check("rst_mem_read",  bus.MEM_READ, 0);
        check("rst_mem_write", bus.MEM_WRITE, 0);
        check("rst_mem_addr",  bus.MEM_ADDRESS, 0);
        check("rst_mem_wdata", bus.MEM_WRITEDATA, 0);
        check("rst_readdata",  bus.READDATA, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Cold read
        cpu_req(1'b1, 1'b0, 8'h25, 8'h00);
        check("cold_stall",   r_stall, 2 + LAT);
        check("cold_wb",      r_wb, 0);
        check("cold_fetch",   r_fe, 1);
        check("cold_fe_addr", r_fe_addr, 6'h09);
        check("cold_data",    r_data, 8'hBB);

        // Write hit then read back
        cpu_req(1'b0, 1'b1, 8'h24, 8'h5A);
        check("wh_stall", r_stall, 0);
        check("wh_strobe", {r_wb, r_fe}, 2'b00);
        cpu_req(1'b1, 1'b0, 8'h24, 8'h00);
        check("wh_rd_stall", r_stall, 0);
        check("wh_rd_data",  r_data, 8'h5A);

        // Dirty eviction
        m29 = mem[6'h29];
        cpu_req(1'b1, 1'b0, 8'hA4, 8'h00);
        check("ev_stall",    r_stall, 2 + 2 * LAT);
        check("ev_wb",       r_wb, 1);
        check("ev_wb_addr",  r_wb_addr, 6'h09);
        check("ev_wb_data",  r_wb_data, 32'hDDCCBB5A);
        check("ev_fe_addr",  r_fe_addr, 6'h29);
        check("ev_data",     r_data, m29[7:0]);
        check("ev_mem9",     mem[9], 32'hDDCCBB5A);
`ifdef DCACHE_STATS_EN
        check("stat_hits",   hit_cnt, 2);
        check("stat_misses", miss_cnt, 2);
`endif

        // READ and WRITE together act as a write
        cpu_req(1'b1, 1'b1, 8'hA5, 8'h77);
        check("rw_stall", r_stall, 0);
        check("rw_array", dut.u_array.data_q[1][15:8], 8'h77);
        check("rw_dirty", dut.u_array.dirty_q[1], 1);
        cpu_req(1'b1, 1'b0, 8'hA5, 8'h00);
        check("rw_rd_data", r_data, 8'h77);

        // Reset during the 3rd FETCH cycle
        bus.READ = 1'b1; bus.ADDRESS = 8'h25;
        n = 0; cyc = 0;
        while (n < 3 && cyc < 100) begin
            @(negedge clk); #1;
            cyc++;
            if (bus.MEM_READ) n++;
        end
        check("rf_reach_fetch", n, 3);
        #1 rst_n = 1'b0;
        #1;
        check("rf_mem_read",  bus.MEM_READ, 0);
        check("rf_mem_write", bus.MEM_WRITE, 0);
        check("rf_valid",     dut.u_array.valid_q, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cpu_req(1'b1, 1'b0, 8'h25, 8'h00);
        check("rf_remiss_stall", r_stall, 2 + LAT);
        check("rf_remiss_fetch", r_fe, 1);
        check("rf_remiss_data",  r_data, 8'hBB);

        // Random traffic against the model
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 64; i++) mem_ref[i] = mem[i];
        for (int i = 0; i < 8; i++) begin
            rv[i] = 1'b0; rdy[i] = 1'b0; rt[i] = '0;
        end
        nh = 0; nm = 0;
        for (int t = 0; t < 150; t++) begin
            tg   = 3'($urandom_range(0, 3));
            ix   = 3'($urandom);
            of   = 2'($urandom);
            a    = {tg, ix, of};
            wd   = 8'($urandom);
            kind = $urandom_range(0, 2);

            hitm = rv[ix] && (rt[ix] == tg);
            wbm  = !hitm && rv[ix] && rdy[ix];
            exp_stall = hitm ? 0 : (wbm ? 2 + 2 * LAT : 2 + LAT);
            vaddr = {rt[ix], ix};
            if (hitm) nh++; else nm++;

            cpu_req(kind != 1, kind != 0, a, wd);

            check("rnd_stall", r_stall, exp_stall);
            check("rnd_wb",    r_wb, wbm);
            check("rnd_fetch", r_fe, !hitm);
            if (wbm) begin
                check("rnd_wb_addr", r_wb_addr, vaddr);
                check("rnd_wb_data", r_wb_data, {rb[ix][3], rb[ix][2], rb[ix][1], rb[ix][0]});
                mem_ref[vaddr] = {rb[ix][3], rb[ix][2], rb[ix][1], rb[ix][0]};
            end
            if (!hitm) begin
                check("rnd_fe_addr", r_fe_addr, {tg, ix});
                for (int k = 0; k < 4; k++) rb[ix][k] = mem_ref[{tg, ix}][8*k +: 8];
                rv[ix] = 1'b1; rdy[ix] = 1'b0; rt[ix] = tg;
            end
            if (kind == 0) begin
                check("rnd_rdata", r_data, rb[ix][of]);
            end else begin
                rb[ix][of] = wd;
                rdy[ix] = 1'b1;
            end
        end
        for (int i = 0; i < 64; i++) check("rnd_mem", mem[i], mem_ref[i]);
`ifdef DCACHE_STATS_EN
        check("rnd_stat_hits",   hit_cnt, nh);
        check("rnd_stat_misses", miss_cnt, nm);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
